// File: rtl/systolic_drain_if.sv
// Output stream from the systolic drain stage to the output SRAM writer:
// one captured accumulator row plus its destination address, valid/ready handshake.
interface systolic_drain_if #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
);
    logic                             out_valid;
    logic                             out_ready;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0]            out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/systolic_drain.sv
// Sweeps the systolic array accumulator rows and streams each row out with its SRAM address.
// Optional per-lane ReLU (sign bit set -> zero) is built when DRAIN_RELU_EN is defined.
module systolic_drain #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             drain_start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    output logic [4:0]                       matrix_index,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] mul_outcome,
    systolic_drain_if.master                 out_if,
    output logic                             busy,
    output logic                             done
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_LAST  = 2'd2;
    localparam logic [4:0] LAST_ROW = 5'(ARRAY_SIZE - 1);

    logic [1:0]                       state_q, state_d;
    logic [4:0]                       row_q, row_d;
    logic [ADDR_WIDTH-1:0]            base_q, base_d;
    logic                             out_valid_q, out_valid_d;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0]            out_addr_q, out_addr_d;
    logic                             done_q, done_d;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] row_data;
    logic                             capture;

`ifdef DRAIN_RELU_EN
    // Sign bit set means negative (including -0.0 and negative NaN): flush the lane to zero.
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_relu
        assign row_data[gi*DATA_WIDTH +: DATA_WIDTH] =
            mul_outcome[gi*DATA_WIDTH + DATA_WIDTH - 1] ? '0 : mul_outcome[gi*DATA_WIDTH +: DATA_WIDTH];
    end
`else
    assign row_data = mul_outcome;
`endif

    // The output register may be refilled in the same cycle its current row is taken.
    assign capture = (state_q == ST_ISSUE) && (!out_valid_q || out_if.out_ready);

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        base_d      = base_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q still high means the previous drain is finishing; busy covers that cycle.
                if (drain_start && !done_q) begin
                    base_d  = base_addr;
                    row_d   = 5'd0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (capture) begin
                    out_data_d  = row_data;
                    out_addr_d  = base_q + ADDR_WIDTH'(row_q);
                    out_valid_d = 1'b1;
                    if (row_q == LAST_ROW) begin
                        state_d = ST_LAST;
                    end else begin
                        row_d = row_q + 5'd1;
                    end
                end
            end
            ST_LAST: begin
                if (out_valid_q && out_if.out_ready) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            base_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            base_q      <= base_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            done_q      <= done_d;
        end
    end

    assign matrix_index     = row_q;
    assign out_if.out_valid = out_valid_q;
    assign out_if.out_data  = out_data_q;
    assign out_if.out_addr  = out_addr_q;
    assign done             = done_q;
    assign busy             = (state_q != ST_IDLE) || done_q;
endmodule
